// File: rtl/act_tile_loader.sv
// act_tile_loader
// Feeds one tile of stream words into the write bank of a 2-bank ping-pong
// activation buffer, then flips the bank select once the consumer has
// released the bank it is reading, so an unconsumed tile is never overwritten.
//
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   start_i, abort_i         begin a tile load (IDLE only) / cancel a load
//   base_addr_i, tile_len_i  tile placement, latched on a legal start
//   s_valid_i/s_data_i/s_ready_o   input word stream
//   buf_wr_en_o/addr_o/data_o      buffer write port (bank = ping_pong_sel_o)
//   ping_pong_sel_o          write bank = sel, read bank = ~sel
//   tile_valid_o             read bank holds an unconsumed tile
//   tile_consumed_i          consumer released the read bank
//   busy_o, done_o, err_o    status / tile-published pulse / bad-config pulse
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for start_i; checks config legality
// S_LOAD | accepting stream words, one buffer write per handshake
// S_FLIP | tile written; waiting for read bank to be free, then flip
module act_tile_loader #(
   parameter int DEPTH      = 16384,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 14
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic                  abort_i,
   input  logic [ADDR_WIDTH-1:0] base_addr_i,
   input  logic [ADDR_WIDTH:0]   tile_len_i,
   input  logic                  s_valid_i,
   input  logic [DATA_WIDTH-1:0] s_data_i,
   output logic                  s_ready_o,
   output logic                  buf_wr_en_o,
   output logic [ADDR_WIDTH-1:0] buf_wr_addr_o,
   output logic [DATA_WIDTH-1:0] buf_wr_data_o,
   output logic                  ping_pong_sel_o,
   output logic                  tile_valid_o,
   input  logic                  tile_consumed_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_FLIP = 2'd2} state_t;

   localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] ONE_W   = (ADDR_WIDTH+1)'(1);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [ADDR_WIDTH:0]   len_q, len_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  f_q, f_d;
   logic                  sel_q, sel_d;
   logic                  s_ready_q, s_ready_d;
   logic                  wr_en_q, wr_en_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;

   logic [ADDR_WIDTH:0]   end_addr;
   logic                  start_legal;
   logic                  accept;
   logic                  flip;

   // len > DEPTH is rejected on its own, so a wrap of end_addr never matters.
   assign end_addr    = {1'b0, base_addr_i} + tile_len_i;
   assign start_legal = (tile_len_i != '0) && (tile_len_i <= DEPTH_W) &&
                        (end_addr <= DEPTH_W);

   // An abort in the same cycle as a handshake wins: the word is not taken.
   assign accept = (state_q == S_LOAD) && s_ready_q && s_valid_i && !abort_i;

   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      len_d     = len_q;
      count_d   = count_q;
      sel_d     = sel_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      flip      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               if (start_legal) begin
                  base_d  = base_addr_i;
                  len_d   = tile_len_i;
                  count_d = '0;
                  state_d = S_LOAD;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_LOAD: begin
            if (abort_i) begin
               state_d = S_IDLE;
            end else if (accept) begin
               wr_en_d   = 1'b1;
               wr_addr_d = base_q + count_q[ADDR_WIDTH-1:0];
               wr_data_d = s_data_i;
               count_d   = count_q + ONE_W;
               if (count_q == len_q - ONE_W) begin
                  state_d = S_FLIP;
               end
            end
         end
         S_FLIP: begin
            if (abort_i) begin
               state_d = S_IDLE;
            end else if (!f_q || tile_consumed_i) begin
               flip    = 1'b1;
               sel_d   = ~sel_q;
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A flip republishes the read bank, so it overrides a same-cycle release.
      f_d = f_q;
      if (tile_consumed_i) begin
         f_d = 1'b0;
      end
      if (flip) begin
         f_d = 1'b1;
      end

      s_ready_d = (state_d == S_LOAD);
      busy_d    = (state_d != S_IDLE);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= S_IDLE;
         base_q    <= '0;
         len_q     <= '0;
         count_q   <= '0;
         f_q       <= 1'b0;
         sel_q     <= 1'b0;
         s_ready_q <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         len_q     <= len_d;
         count_q   <= count_d;
         f_q       <= f_d;
         sel_q     <= sel_d;
         s_ready_q <= s_ready_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign s_ready_o       = s_ready_q;
   assign buf_wr_en_o     = wr_en_q;
   assign buf_wr_addr_o   = wr_addr_q;
   assign buf_wr_data_o   = wr_data_q;
   assign ping_pong_sel_o = sel_q;
   assign tile_valid_o    = f_q;
   assign busy_o          = busy_q;
   assign done_o          = done_q;
   assign err_o           = err_q;

endmodule

// File: doc/act_tile_loader.md
Name: act_tile_loader

Overview:
- Upstream feeder for the 2-bank ping-pong activation buffer.
- Accepts a valid/ready word stream from DMA/CPU, writes one tile of words into the buffer bank currently selected for writing, then flips the ping-pong select so the multi-lane unit reads the new tile.
- Flips only after the consumer has released the bank it is currently reading, so no unconsumed tile is ever overwritten.

Parameters:
DEPTH, 16384, words per buffer bank
DATA_WIDTH, 32, stream and buffer word width
ADDR_WIDTH, 14, buffer word address width (log2 DEPTH)

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
start_i  input  1  begin loading one tile (sampled in IDLE only)
abort_i  input  1  synchronous abort of an in-progress load
base_addr_i  input  ADDR_WIDTH  first buffer word address of tile, latched on start
tile_len_i  input  ADDR_WIDTH+1  tile length in words, latched on start
s_valid_i  input  1  stream word valid
s_data_i  input  DATA_WIDTH  stream word
s_ready_o  output  1  loader accepts stream word
buf_wr_en_o  output  1  buffer write strobe
buf_wr_addr_o  output  ADDR_WIDTH  buffer write address
buf_wr_data_o  output  DATA_WIDTH  buffer write data
ping_pong_sel_o  output  1  buffer bank select (write bank = sel, read bank = ~sel)
tile_valid_o  output  1  read bank holds an unconsumed tile
tile_consumed_i  input  1  consumer pulse: finished with read bank
busy_o  output  1  state != IDLE
done_o  output  1  one-cycle pulse: tile published (bank flipped)
err_o  output  1  one-cycle pulse: illegal start config rejected

Behaviour:
- Reset (async, rst_ni=0):
  - State IDLE.
  - All outputs 0: s_ready_o, buf_wr_en_o, buf_wr_addr_o, buf_wr_data_o, ping_pong_sel_o, tile_valid_o, busy_o, done_o, err_o.
  - Internal full flag F=0 and word counter cleared.
  - Reset mid-load discards the partial tile; no flip occurs.
- tile_valid_o = F (registered).
  - F is set on a flip.
  - F is cleared by tile_consumed_i when F=1; tile_consumed_i when F=0 is ignored.
- IDLE:
  - On start_i, check legality: tile_len_i in 1..DEPTH and base_addr_i + tile_len_i <= DEPTH (compare at ADDR_WIDTH+1 bits).
  - Legal start: latch base/len, count=0, go to LOAD.
  - Illegal start: err_o pulses the next cycle and the loader stays in IDLE.
- LOAD:
  - s_ready_o=1 (registered, first high the cycle after start).
  - Each s_valid_i&&s_ready_o handshake accepts one word.
  - Next cycle: buf_wr_en_o=1, buf_wr_addr_o=base+count, buf_wr_data_o=word; count increments.
  - Gaps in s_valid_i produce no writes.
  - The handshake that accepts word len-1 moves the loader to FLIP, and s_ready_o drops in that same edge.
  - No extra word is accepted.
- FLIP:
  - In the first FLIP cycle, buf_wr_en_o presents the last word under the old sel; that write lands on the closing edge.
  - At the edge ending any FLIP cycle where (F==0 || tile_consumed_i), the loader:
    - toggles sel
    - sets F=1
    - pulses done_o (visible the next cycle)
    - returns to IDLE
  - Otherwise it waits in FLIP, with buf_wr_en_o=0 after the first cycle.
  - Simultaneous tile_consumed_i and flip: F stays 1.
- abort_i:
  - In LOAD or FLIP: return to IDLE next cycle with s_ready_o=0. No flip, no done_o; F and sel are unchanged.
  - A write already registered for the current cycle still completes.
  - In IDLE, abort_i is ignored.
- start_i outside IDLE is ignored.
- start_i in the same cycle as the done_o pulse is accepted (the loader is already in IDLE).
- Throughput: 1 word/cycle.
- Latency, tile of N words, consumer free, stream always valid:
  - start at cycle 0; accepts on cycles 1..N; last write at N+1.
  - sel/tile_valid_o/done_o change at N+2.

Test Plan:
- Reset: assert rst_ni low mid-LOAD asynchronously -> all outputs 0 immediately, sel=0; after release, a new start loads normally.
- Basic tile: base=0x010, len=4, data A0..A3 continuous, F=0, start at cycle 0 -> writes 0x010..0x013 with A0..A3 at cycles 2..5; sel=1, tile_valid_o=1, done_o=1 at cycle 6.
- Backpressure/gaps: len=3, s_valid_i pattern 1,0,0,1,1 -> exactly 3 writes, addresses consecutive, no write in gap cycles, done_o after the third write.
- Consumer stall: second tile len=2 while F=1 -> loader holds in FLIP with busy_o=1. Pulse tile_consumed_i 5 cycles later -> sel toggles back to 0 at that edge and F stays 1.
- Illegal configs: len=0, len=16385, and base=16380 with len=8 -> err_o pulses each time; no s_ready_o, no writes, busy_o stays 0.
- Abort: len=8, abort_i after 3 accepted words -> 3 writes only, IDLE next cycle, sel/tile_valid_o unchanged, no done_o.
